// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the fetch stage and the main control decoder:
//   - MAINCTL opcode constants (inst[31:26])
//   - fetch state machine encoding
//   - default reset PC
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes decoded by MAINCTL from inst[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Default reset vector; must be word aligned.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Fetch sequencing: one cycle of boot, then alternate request / hold.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
// Instruction-memory read channel (single outstanding word read).
//   imem_req   : read request, held until imem_ack
//   imem_addr  : word-aligned byte address, stable while imem_req=1
//   imem_ack   : imem_rdata is valid this cycle
//   imem_rdata : returned instruction word
// master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/inst_fetch_unit_next_pc_logic.sv
// -----------------------------------------------------------------------------
// next_pc_logic
// Purely combinational next-PC selection, shared with future pipelined fetch.
//   pc_plus4 : address of the sequentially following instruction
//   inst     : jump index field inst[25:0]
//   imm_ext  : sign-extended branch offset (in words)
//   Branch, Jump, Zero : decoder / ALU controls
//   next_pc  : selected target (Jump > taken branch > sequential)
// -----------------------------------------------------------------------------
module next_pc_logic (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] inst,
  input  logic [31:0] imm_ext,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  // NOTE: the default assignment at the top of a combinational block is what
  // keeps it latch-free; every path then leaves next_pc driven.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump) begin
      // Jump stays within the current 256 MB region.
      next_pc = {pc_plus4[31:28], inst, 2'b00};
    end else if (Branch && Zero) begin
      // Word offset relative to pc+4; 32-bit wrap is intentional.
      next_pc = pc_plus4 + (imm_ext << 2);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage feeding MAINCTL and the datapath.
// Holds the PC, reads one word at a time from instruction memory, presents it
// as inst/inst_valid and advances the PC when the datapath commits it.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction-memory read channel (master side)
//   inst         : latched instruction (inst[31:26] -> MAINCTL)
//   inst_valid   : inst holds a fetched, not yet committed instruction
//   inst_ready   : datapath commits inst this cycle
//   pc, pc_plus4 : address of inst and its sequential successor
//   Branch, Jump, Zero, imm_ext : next-PC controls, used only on commit
//   inst_count   : retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_fetch_unit_if.master  imem,
  output logic [31:0]        inst,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               Zero,
  input  logic [31:0]        imm_ext,
  output logic [CNT_W-1:0]   inst_count
);

  // Low address bits are forced to zero so the reset vector is always aligned.
  localparam logic [31:0] PC_RESET_ALIGNED = {PC_RESET[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic         load_inst;
  logic         retire;
  logic [31:0]  next_pc;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // imem_ack is only honoured in S_REQ, and Branch/Jump/Zero only matter via
  // retire, so stray inputs in other states have no effect.
  always_comb begin
    state_d   = state_q;
    load_inst = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem.imem_ack) begin
          load_inst = 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          retire  = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Request and valid decode straight from the state register, so reset
  // removes imem_req asynchronously.
  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc;
  assign inst_valid     = (state_q == S_HOLD);
  assign pc_plus4       = pc + 32'd4;

  next_pc_logic u_next_pc (
    .pc_plus4 (pc_plus4),
    .inst     (inst[25:0]),
    .imm_ext  (imm_ext),
    .Branch   (Branch),
    .Jump     (Jump),
    .Zero     (Zero),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= PC_RESET_ALIGNED;
      inst       <= 32'h0;
      inst_count <= '0;
    end else begin
      if (load_inst) inst <= imem.imem_rdata;
      if (retire) begin
        pc         <= next_pc;
        inst_count <= inst_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Self-checking bench: a memory model answers fetch requests; expected
// addresses are queued when the previous instruction is retired and expected
// instruction words when the memory answers, then popped and compared when
// the DUT issues the request / presents inst.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] imm_ext;
  logic [15:0] inst_count;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .PC_RESET (PC_RST),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .Branch     (Branch),
    .Jump       (Jump),
    .Zero       (Zero),
    .imm_ext    (imm_ext),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] cur_pc;
  logic [31:0] cur_inst;
  logic [15:0] exp_count;

  localparam logic [31:0] W_RTYPE = 32'h0000_0020;
  localparam logic [31:0] W_J10   = 32'h0800_0004;  // j -> 0x10 in region 0
  localparam logic [31:0] W_BEQ   = 32'h1000_0003;

  // All tasks start and end just after a falling edge.
  task automatic clear_inputs();
    inst_ready     = 1'b0;
    Branch         = 1'b0;
    Jump           = 1'b0;
    Zero           = 1'b0;
    imm_ext        = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_count = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_addr_q.push_back(PC_RST);
    @(negedge clk);
  endtask

  // Serve one fetch: wait for the request, check its address, hold off the
  // ack for 'lat' cycles, return 'word' and check the presented instruction.
  task automatic fetch(input logic [31:0] word, input int lat);
    logic [31:0] exp_a;
    logic [31:0] exp_i;
    int          waited;
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (bus.imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_req_timeout: imem_req=%b, required 1", bus.imem_req);
      return;
    end
    if (exp_addr_q.size() == 0) begin
      tests_failed++;
      $display("FAIL fetch_unexpected: request at %h with no expected address", bus.imem_addr);
      return;
    end
    exp_a = exp_addr_q.pop_front();
    if (bus.imem_addr !== exp_a) begin
      tests_failed++;
      $display("FAIL fetch_addr: imem_addr=%h, required %h", bus.imem_addr, exp_a);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_a || inst_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL fetch_wait: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                 bus.imem_req, bus.imem_addr, inst_valid, exp_a);
      end
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    exp_inst_q.push_back(word);
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    exp_i = exp_inst_q.pop_front();
    tests_run++;
    if (inst_valid !== 1'b1 || inst !== exp_i) begin
      tests_failed++;
      $display("FAIL fetch_inst: valid=%b inst=%h, required valid=1 inst=%h", inst_valid, inst, exp_i);
    end
    tests_run++;
    if (pc !== exp_a || pc_plus4 !== exp_a + 32'd4 || bus.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_pc: pc=%h pc_plus4=%h req=%b, required pc=%h pc_plus4=%h req=0",
               pc, pc_plus4, bus.imem_req, exp_a, exp_a + 32'd4);
    end
    cur_pc   = exp_a;
    cur_inst = exp_i;
  endtask

  // Commit the held instruction with the given controls; the next fetch must
  // come from exp_next.
  task automatic retire(input logic br, input logic jp, input logic zr,
                        input logic [31:0] imm, input logic [31:0] exp_next);
    Branch     = br;
    Jump       = jp;
    Zero       = zr;
    imm_ext    = imm;
    inst_ready = 1'b1;
    exp_addr_q.push_back(exp_next);
    exp_count++;
    @(negedge clk);
    clear_inputs();
    tests_run++;
    if (inst_count !== exp_count) begin
      tests_failed++;
      $display("FAIL retire_count: inst_count=%0d, required %0d", inst_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_count = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
        pc !== PC_RST || inst_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_values: req=%b valid=%b inst=%h pc=%h cnt=%0d, required 0 0 0 %h 0",
               bus.imem_req, inst_valid, inst, pc, inst_count, PC_RST);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_req: imem_req=%b, required 0", bus.imem_req);
    end
    @(negedge clk);
    tests_run++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== PC_RST) begin
      tests_failed++;
      $display("FAIL first_req: req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, PC_RST);
    end
    exp_addr_q.push_back(PC_RST);
    fetch(W_RTYPE, 0);
  endtask

  task automatic test_sequential();
    apply_reset();
    fetch(W_RTYPE, 3);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
    fetch(32'h0022_1820, 3);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h8);
    fetch(32'h8C22_0004, 3);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 32'hC);
    tests_run++;
    if (inst_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL seq_count: inst_count=%0d, required 3", inst_count);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    fetch(W_J10, 0);
    retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h10);
    fetch(W_BEQ, 1);
    retire(1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h20);   // taken forward
    fetch(W_J10, 0);
    retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h10);
    fetch(W_BEQ, 0);
    retire(1'b1, 1'b0, 1'b0, 32'h0000_0003, 32'h14);   // not taken
    fetch(W_J10, 0);
    retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h10);
    fetch(W_BEQ, 2);
    retire(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0C);   // taken backward
    fetch(W_BEQ, 0);
  endtask

  task automatic test_jump_priority();
    // From 0x0C, a large taken branch reaches region 1: 0x10 + 0x0FFFFFF0.
    retire(1'b1, 1'b0, 1'b1, 32'h03FF_FFFC, 32'h1000_0000);
    fetch(32'h0800_0040, 0);
    retire(1'b1, 1'b1, 1'b1, 32'h0000_0003, 32'h1000_0100);
    fetch(W_RTYPE, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      inst_ready = 1'b0;
      Branch     = 1'b1;
      Jump       = 1'b1;
      Zero       = 1'b1;
      imm_ext    = 32'h0000_0100;
      bus.imem_ack   = (i == 2);
      bus.imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      tests_run++;
      if (pc !== cur_pc || inst !== cur_inst || inst_valid !== 1'b1 ||
          bus.imem_req !== 1'b0 || inst_count !== exp_count) begin
        tests_failed++;
        $display("FAIL stall_%0d: pc=%h inst=%h valid=%b req=%b cnt=%0d, required %h %h 1 0 %0d",
                 i, pc, inst, inst_valid, bus.imem_req, inst_count, cur_pc, cur_inst, exp_count);
      end
    end
    clear_inputs();
    retire(1'b0, 1'b0, 1'b0, 32'h0, cur_pc + 32'd4);
  endtask

  task automatic test_reset_mid_request();
    tests_run++;
    if (bus.imem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre: imem_req=%b, required 1", bus.imem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.imem_req !== 1'b0 || pc !== PC_RST || inst_valid !== 1'b0 ||
        inst !== 32'h0 || inst_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL midrst_async: req=%b pc=%h valid=%b inst=%h cnt=%0d, required 0 %h 0 0 0",
               bus.imem_req, pc, inst_valid, inst, inst_count, PC_RST);
    end
    exp_addr_q.delete();
    exp_inst_q.delete();
    exp_count = '0;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.imem_ack   = 1'b1;           // late ack lands while in boot
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    clear_inputs();
    tests_run++;
    if (inst !== 32'h0 || inst_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
        bus.imem_addr !== PC_RST) begin
      tests_failed++;
      $display("FAIL midrst_boot_ack: inst=%h valid=%b req=%b addr=%h, required 0 0 1 %h",
               inst, inst_valid, bus.imem_req, bus.imem_addr, PC_RST);
    end
    exp_addr_q.push_back(PC_RST);
    fetch(W_RTYPE, 1);
    retire(1'b0, 1'b0, 1'b0, 32'h0, PC_RST + 32'd4);
    fetch(W_RTYPE, 0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
